// File: rtl/line_clear_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | line_clear_engine                                                         |
// | Scans the board bottom-up, compacts non-full rows downward through the    |
// | column RAMs and zero-fills the vacated rows at the top.                   |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
module line_clear_engine #(
    parameter int ROWS = 22,
    parameter int COLS = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [4:0]           ram_row,
    input  logic [COLS*24-1:0]   rd_data,
    output logic [COLS*24-1:0]   wr_data,
    output logic [COLS-1:0]      we,
    output logic                 busy,
    output logic                 done,
    output logic [4:0]           lines,
    output logic [9:0]           total_lines
);

    localparam int         c_CELL_W = 24;
    localparam int         c_ROW_W  = COLS * c_CELL_W;
    localparam logic [4:0] c_BOTTOM = 5'(ROWS - 1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_READ  = 3'd1;
    localparam logic [2:0] c_ST_WAIT  = 3'd2;
    localparam logic [2:0] c_ST_EVAL  = 3'd3;
    localparam logic [2:0] c_ST_WRITE = 3'd4;
    localparam logic [2:0] c_ST_FILL  = 3'd5;
    localparam logic [2:0] c_ST_DONE  = 3'd6;

    logic [2:0]         r_state, w_state_next;
    logic [4:0]         r_src, w_src_next;
    logic [4:0]         r_dst, w_dst_next;
    // One bit wider than the port so a fully cleared 32-row board still reads as non-zero.
    logic [5:0]         r_lines, w_lines_next;
    logic [9:0]         r_total;
    logic [c_ROW_W-1:0] r_row_buf;
    logic               w_latch;
    logic               w_src_step;
    logic [COLS-1:0]    w_cell_nz;
    logic               w_row_full;

    for (genvar i = 0; i < COLS; i++) begin : g_col
        assign w_cell_nz[i] = |rd_data[i*c_CELL_W +: c_CELL_W];
    end
    assign w_row_full = &w_cell_nz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src     <= '0;
            r_dst     <= '0;
            r_lines   <= '0;
            r_total   <= '0;
            r_row_buf <= '0;
        end else begin
            r_src   <= w_src_next;
            r_dst   <= w_dst_next;
            r_lines <= w_lines_next;
            if (w_latch) begin
                r_row_buf <= rd_data;
            end
            if (r_state == c_ST_DONE) begin
                r_total <= r_total + 10'(r_lines);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_src_next   = r_src;
        w_dst_next   = r_dst;
        w_lines_next = r_lines;
        w_latch      = 1'b0;
        w_src_step   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_src_next   = c_BOTTOM;
                    w_dst_next   = c_BOTTOM;
                    w_lines_next = '0;
                    w_state_next = c_ST_READ;
                end
            end
            c_ST_READ: w_state_next = c_ST_WAIT;
            c_ST_WAIT: w_state_next = c_ST_EVAL;
            c_ST_EVAL: begin
                if (w_row_full) begin
                    w_lines_next = r_lines + 6'd1;
                    w_src_step   = 1'b1;
                end else if (r_src == r_dst) begin
                    w_dst_next = r_dst - 5'd1;
                    w_src_step = 1'b1;
                end else begin
                    w_latch      = 1'b1;
                    w_state_next = c_ST_WRITE;
                end
            end
            c_ST_WRITE: begin
                w_dst_next = r_dst - 5'd1;
                w_src_step = 1'b1;
            end
            c_ST_FILL: begin
                if (r_dst == 5'd0) begin
                    w_state_next = c_ST_DONE;
                end else begin
                    w_dst_next = r_dst - 5'd1;
                end
            end
            c_ST_DONE: w_state_next = c_ST_IDLE;
            default:   w_state_next = c_ST_IDLE;
        endcase
        // Shared source-row advance; the lines test sees this cycle's increment.
        if (w_src_step) begin
            if (r_src == 5'd0) begin
                w_state_next = (w_lines_next != 6'd0) ? c_ST_FILL : c_ST_DONE;
            end else begin
                w_src_next   = r_src - 5'd1;
                w_state_next = c_ST_READ;
            end
        end
    end

    always_comb begin
        ram_row = '0;
        wr_data = '0;
        we      = '0;
        case (r_state)
            // Address stays on src through EVAL so the RAM keeps presenting that row.
            c_ST_READ, c_ST_WAIT, c_ST_EVAL: ram_row = r_src;
            c_ST_WRITE: begin
                ram_row = r_dst;
                wr_data = r_row_buf;
                we      = '1;
            end
            c_ST_FILL: begin
                ram_row = r_dst;
                we      = '1;
            end
            default: ;
        endcase
    end

    assign busy        = (r_state != c_ST_IDLE);
    assign done        = (r_state == c_ST_DONE);
    assign lines       = r_lines[4:0];
    assign total_lines = r_total;

endmodule
`default_nettype wire

// File: tb/tb_line_clear_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_line_clear_engine                                                      |
// | Random and directed boards against a row-compaction reference model.      |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
module tb_line_clear_engine;

    localparam int ROWS = 22;
    localparam int COLS = 10;
    localparam int W    = COLS * 24;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [4:0]    ram_row;
    logic [W-1:0]  rd_data;
    logic [W-1:0]  wr_data;
    logic [COLS-1:0] we;
    logic          busy;
    logic          done;
    logic [4:0]    lines;
    logic [9:0]    total_lines;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] mem [ROWS];
    logic [W-1:0] img [ROWS];
    logic [W-1:0] exp_board [ROWS];
    logic [W-1:0] rd_q;
    logic         load_req = 1'b0;
    int           exp_lines;
    int           exp_writes;
    int           exp_total;

    line_clear_engine #(.ROWS(ROWS), .COLS(COLS)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .ram_row     (ram_row),
        .rd_data     (rd_data),
        .wr_data     (wr_data),
        .we          (we),
        .busy        (busy),
        .done        (done),
        .lines       (lines),
        .total_lines (total_lines)
    );

    always #5 clk = ~clk;

    // Column RAMs: synchronous read with one cycle of latency, per-column write.
    assign rd_data = rd_q;
    always @(posedge clk) begin
        if (load_req) begin
            mem <= img;
        end else if (ram_row < ROWS) begin
            for (int c = 0; c < COLS; c++) begin
                if (we[c]) mem[ram_row][c*24 +: 24] <= wr_data[c*24 +: 24];
            end
        end
        rd_q <= (ram_row < ROWS) ? mem[ram_row] : '0;
    end

    function automatic bit row_full(input logic [W-1:0] row);
        for (int c = 0; c < COLS; c++) begin
            if (row[c*24 +: 24] == 24'h0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [W-1:0] full_row();
        logic [W-1:0] r;
        for (int c = 0; c < COLS; c++) r[c*24 +: 24] = 24'($urandom_range(1, 24'hFFFFFF));
        return r;
    endfunction

    function automatic logic [W-1:0] partial_row();
        logic [W-1:0] r;
        r = '0;
        if ($urandom_range(0, 4) != 0) begin
            for (int c = 0; c < COLS; c++) begin
                if ($urandom_range(0, 1) == 1) r[c*24 +: 24] = 24'($urandom_range(1, 24'hFFFFFF));
            end
            r[$urandom_range(0, COLS-1)*24 +: 24] = 24'h0;
        end
        return r;
    endfunction

    // Reference: surviving rows keep their order and settle at the bottom.
    task automatic compute_expected();
        int k;
        k = ROWS - 1;
        exp_lines  = 0;
        exp_writes = 0;
        for (int r = 0; r < ROWS; r++) exp_board[r] = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (row_full(img[r])) begin
                exp_lines++;
            end else begin
                exp_board[k] = img[r];
                if (k != r) exp_writes++;
                k--;
            end
        end
        if (exp_lines > 0) exp_writes += exp_lines;
        exp_total = (exp_total + exp_lines) % 1024;
    endtask

    function automatic int board_mismatches();
        int bad;
        bad = 0;
        for (int r = 0; r < ROWS; r++) if (mem[r] !== exp_board[r]) bad++;
        return bad;
    endfunction

    task automatic load_board();
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        compute_expected();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_total = 0;
    endtask

    // Cycle count is inclusive: the start cycle through the done cycle.
    task automatic run_op(input bit poke, output int cycles, output int writes,
                          output int lines_obs, output bit tmo);
        writes = 0;
        tmo    = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        cycles = 2;
        while (done !== 1'b1 && cycles < 3000) begin
            if (we !== '0) writes++;
            start = (poke && cycles == 6);
            @(posedge clk);
            #1;
            cycles++;
        end
        start = 1'b0;
        tmo = (done !== 1'b1);
        lines_obs = int'(lines);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        start = 1'b0;
        for (int r = 0; r < ROWS; r++) img[r] = '0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, we, ram_row, lines, total_lines} !== '0 || wr_data !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: busy=%b done=%b we=%h row=%0d lines=%0d total=%0d, required all zero",
                     busy, done, we, ram_row, lines, total_lines);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_total = 0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_idle_busy: got %b required 0", busy);
        end
    endtask

    task automatic test_empty();
        int cyc, wr, lo;
        bit tmo;
        for (int r = 0; r < ROWS; r++) img[r] = '0;
        load_board();
        run_op(1'b0, cyc, wr, lo, tmo);
        n_checks++;
        if (tmo || cyc != 3*ROWS + 2) begin
            n_errors++;
            $display("FAIL empty_latency: got %0d cycles (timeout=%b) required %0d", cyc, tmo, 3*ROWS + 2);
        end
        n_checks++;
        if (lo != 0 || wr != 0) begin
            n_errors++;
            $display("FAIL empty_result: lines=%0d writes=%0d required 0 and 0", lo, wr);
        end
        n_checks++;
        if (ram_row !== 5'd0 || wr_data !== '0 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL done_cycle_bus: row=%0d busy=%b wr_data_nz=%b required 0,1,0", ram_row, busy, |wr_data);
        end
    endtask

    task automatic test_directed();
        int cyc, wr, lo;
        bit tmo;
        logic [W-1:0] pat_a, pat_b;
        // Single clear with one coloured cell dropping into the bottom row.
        for (int r = 0; r < ROWS; r++) img[r] = '0;
        img[21] = full_row();
        img[20] = 240'h66B2FF;
        load_board();
        run_op(1'b0, cyc, wr, lo, tmo);
        @(posedge clk);
        #1;
        n_checks++;
        if (tmo || mem[21] !== 240'h66B2FF || mem[20] !== '0 || lo != 1 || total_lines !== 10'd1) begin
            n_errors++;
            $display("FAIL single_clear: row21=%h lines=%0d total=%0d required row21=66b2ff lines=1 total=1",
                     mem[21][23:0], lo, total_lines);
        end
        // Four stacked clears with one pattern above them.
        pat_a = partial_row() | 240'h1;
        for (int r = 0; r < ROWS; r++) img[r] = '0;
        for (int r = 18; r < 22; r++) img[r] = full_row();
        img[17] = pat_a;
        load_board();
        run_op(1'b0, cyc, wr, lo, tmo);
        n_checks++;
        if (tmo || mem[21] !== pat_a || board_mismatches() != 0 || lo != 4) begin
            n_errors++;
            $display("FAIL quad_clear: lines=%0d row_mismatches=%0d required lines=4 mismatches=0",
                     lo, board_mismatches());
        end
        // Interleaved full and partial rows.
        pat_a = partial_row() | 240'h2;
        pat_b = partial_row() | 240'h3;
        for (int r = 0; r < ROWS; r++) img[r] = '0;
        img[21] = full_row();
        img[20] = pat_a;
        img[19] = full_row();
        img[18] = pat_b;
        load_board();
        run_op(1'b0, cyc, wr, lo, tmo);
        n_checks++;
        if (tmo || mem[21] !== pat_a || mem[20] !== pat_b || board_mismatches() != 0 || lo != 2) begin
            n_errors++;
            $display("FAIL interleaved: lines=%0d row_mismatches=%0d required lines=2 mismatches=0",
                     lo, board_mismatches());
        end
    endtask

    task automatic test_random();
        int cyc, wr, lo, pfull;
        bit tmo;
        for (int t = 0; t < 12; t++) begin
            pfull = (t == 11) ? 100 : $urandom_range(10, 60);
            for (int r = 0; r < ROWS; r++) img[r] = ($urandom_range(0, 99) < pfull) ? full_row() : partial_row();
            load_board();
            run_op(t[0], cyc, wr, lo, tmo);
            @(posedge clk);
            #1;
            n_checks++;
            if (tmo || board_mismatches() != 0 || lo != exp_lines || wr != exp_writes) begin
                n_errors++;
                $display("FAIL random_board[%0d]: lines=%0d writes=%0d mismatches=%0d required lines=%0d writes=%0d mismatches=0",
                         t, lo, wr, board_mismatches(), exp_lines, exp_writes);
            end
            n_checks++;
            if (total_lines !== 10'(exp_total)) begin
                n_errors++;
                $display("FAIL random_total[%0d]: got %0d required %0d", t, total_lines, exp_total);
            end
        end
    endtask

    task automatic test_back_to_back();
        int cyc, wr, lo;
        bit tmo;
        for (int r = 0; r < ROWS; r++) img[r] = ($urandom_range(0, 1) == 1) ? full_row() : partial_row();
        load_board();
        run_op(1'b0, cyc, wr, lo, tmo);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_checks++;
        if (tmo || busy !== 1'b0 || lines !== 5'(exp_lines)) begin
            n_errors++;
            $display("FAIL start_at_done: busy=%b lines=%0d required busy=0 lines=%0d", busy, lines, exp_lines);
        end
        for (int r = 0; r < ROWS; r++) img[r] = ($urandom_range(0, 2) == 0) ? full_row() : partial_row();
        load_board();
        run_op(1'b0, cyc, wr, lo, tmo);
        n_checks++;
        if (tmo || board_mismatches() != 0 || lo != exp_lines) begin
            n_errors++;
            $display("FAIL back_to_back: lines=%0d mismatches=%0d required lines=%0d mismatches=0",
                     lo, board_mismatches(), exp_lines);
        end
    endtask

    task automatic test_total_wrap();
        int cyc, wr, lo;
        bit tmo;
        do_reset();
        for (int n = 0; n < 46; n++) begin
            for (int r = 0; r < ROWS; r++) img[r] = full_row();
            load_board();
            run_op(1'b0, cyc, wr, lo, tmo);
        end
        for (int r = 0; r < ROWS; r++) img[r] = (r >= 12) ? full_row() : partial_row();
        load_board();
        run_op(1'b0, cyc, wr, lo, tmo);
        @(posedge clk);
        #1;
        n_checks++;
        if (tmo || total_lines !== 10'd1022) begin
            n_errors++;
            $display("FAIL total_preload: got %0d required 1022", total_lines);
        end
        for (int r = 0; r < ROWS; r++) img[r] = partial_row();
        for (int k = 0; k < 4; k++) img[3 + 5*k] = full_row();
        load_board();
        run_op(1'b0, cyc, wr, lo, tmo);
        @(posedge clk);
        #1;
        n_checks++;
        if (tmo || total_lines !== 10'd2 || lo != 4 || board_mismatches() != 0) begin
            n_errors++;
            $display("FAIL total_wrap: total=%0d lines=%0d required total=2 lines=4", total_lines, lo);
        end
    endtask

    task automatic test_reset_mid_fill();
        int cyc, wr, lo, wait_cyc;
        bit tmo;
        for (int r = 0; r < ROWS; r++) img[r] = full_row();
        load_board();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cyc = 0;
        while (we === '0 && wait_cyc < 500) begin
            @(negedge clk);
            wait_cyc++;
        end
        n_checks++;
        if (we !== '1) begin
            n_errors++;
            $display("FAIL fill_reached: we=%h after %0d cycles required 3ff", we, wait_cyc);
        end
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (we !== '0 || busy !== 1'b0 || done !== 1'b0 || total_lines !== '0 || lines !== '0 || ram_row !== '0) begin
            n_errors++;
            $display("FAIL reset_mid_fill: we=%h busy=%b done=%b total=%0d lines=%0d row=%0d required all zero",
                     we, busy, done, total_lines, lines, ram_row);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_total = 0;
        for (int r = 0; r < ROWS; r++) img[r] = ($urandom_range(0, 1) == 1) ? full_row() : partial_row();
        load_board();
        run_op(1'b0, cyc, wr, lo, tmo);
        @(posedge clk);
        #1;
        n_checks++;
        if (tmo || board_mismatches() != 0 || lo != exp_lines || total_lines !== 10'(exp_total)) begin
            n_errors++;
            $display("FAIL after_reset_op: lines=%0d total=%0d mismatches=%0d required lines=%0d total=%0d",
                     lo, total_lines, board_mismatches(), exp_lines, exp_total);
        end
    endtask

    initial begin
        exp_total = 0;
        test_reset();
        test_empty();
        test_directed();
        test_random();
        test_back_to_back();
        test_total_wrap();
        test_reset_mid_fill();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
